// File: rtl/image_row_streamer.sv
// image_row_streamer
//   Pixel source for the 3x3 filter top. Reads an 8-bit grayscale image from a
//   1-cycle-latency RAM and streams it to the filter slave port: PRIME_ROWS rows
//   back-to-back after start, then one row per rising filter interrupt, then
//   FLUSH_ROWS rows of zeros (also one per interrupt).
//   Optional feature macro: STREAMER_TLAST_EN adds o_data_last, asserted with
//   o_data_valid on the last beat of every row.
module image_row_streamer #(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512,
  parameter int unsigned PRIME_ROWS = 4,
  parameter int unsigned FLUSH_ROWS = 2,
  parameter int unsigned ADDR_W     = 18
) (
  input  logic              axi_clk,
  input  logic              axi_reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]        i_rd_data,
  output logic              o_data_valid,
  output logic [7:0]        o_data,
  input  logic              i_data_ready,
`ifdef STREAMER_TLAST_EN
  output logic              o_data_last,
`endif
  input  logic              i_intr
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT + 1);
  localparam int unsigned FL_W  = $clog2(FLUSH_ROWS + 2);

  localparam logic [CNT_W-1:0] PRIME_LEN  = CNT_W'(PRIME_ROWS * IMG_WIDTH);
  localparam logic [CNT_W-1:0] ROW_LEN    = CNT_W'(IMG_WIDTH);
  localparam logic [ROW_W-1:0] ROWS_ALL   = ROW_W'(IMG_HEIGHT);
  localparam logic [ROW_W-1:0] ROWS_PRIME = ROW_W'(PRIME_ROWS);
  localparam logic [FL_W-1:0]  FLUSH_ALL  = FL_W'(FLUSH_ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_WAIT,
    S_ROW,
    S_FWAIT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_W-1:0] r_rd_addr;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [ROW_W-1:0]  r_rows_sent;
  logic [FL_W-1:0]   r_flush_sent;

  logic              r_intr_q;
  logic              r_pending;
  logic              r_err;

  logic              r_inflight;
  logic [7:0]        r_fifo_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_fifo_cnt;

  logic              w_start;
  logic              w_rd_state;
  logic [CNT_W-1:0]  w_burst_len;
  logic [2:0]        w_occupancy;
  logic              w_fifo_valid;
  logic [7:0]        w_fifo_data;
  logic              w_valid;
  logic [7:0]        w_data;
  logic              w_beat;
  logic              w_row_end;
  logic              w_last_beat;
  logic              w_rd_en;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_rise;
  logic              w_intr_window;
  logic              w_take_pending;

  // Datapath: skid-buffer output selection, beat detection and read issue.
  // When the buffer is empty the RAM output is forwarded directly so the first
  // pixel appears two cycles after start; an unaccepted forwarded pixel is
  // captured into the buffer, which keeps o_data stable during a stall.
  always_comb begin
    w_start       = 1'b0;
    w_rd_state    = 1'b0;
    w_burst_len   = ROW_LEN;
    w_occupancy   = '0;
    w_fifo_valid  = 1'b0;
    w_fifo_data   = '0;
    w_valid       = 1'b0;
    w_data        = '0;
    w_beat        = 1'b0;
    w_row_end     = 1'b0;
    w_last_beat   = 1'b0;
    w_rd_en       = 1'b0;
    w_fifo_push   = 1'b0;
    w_fifo_pop    = 1'b0;
    w_rise        = 1'b0;
    w_intr_window = 1'b0;

    w_start     = (r_state == S_IDLE) && i_start;
    w_rd_state  = (r_state == S_PRIME) || (r_state == S_ROW);
    w_burst_len = (r_state == S_PRIME) ? PRIME_LEN : ROW_LEN;
    w_occupancy = {1'b0, r_fifo_cnt} + {2'b00, r_inflight};

    w_fifo_valid = (r_fifo_cnt != 2'd0) || r_inflight;
    w_fifo_data  = (r_fifo_cnt != 2'd0) ? r_fifo_mem[r_rd_ptr] : i_rd_data;

    if (r_state == S_FLUSH) begin
      w_valid = 1'b1;
      w_data  = '0;
    end else if (w_fifo_valid) begin
      w_valid = 1'b1;
      w_data  = w_fifo_data;
    end

    w_beat      = w_valid && i_data_ready;
    w_row_end   = (r_beat_cnt == w_burst_len - 1'b1);
    w_last_beat = w_beat && w_row_end;

    w_rd_en = w_rd_state && (r_rd_cnt < w_burst_len) && (w_occupancy < 3'd2);

    w_fifo_pop  = w_beat && (r_fifo_cnt != 2'd0);
    w_fifo_push = r_inflight && !(w_beat && (r_fifo_cnt == 2'd0));

    w_rise        = i_intr && !r_intr_q;
    w_intr_window = (r_state == S_WAIT) || (r_state == S_ROW) ||
                    (r_state == S_FWAIT) || (r_state == S_FLUSH);
  end

  // Next-state logic; also flags when the pending interrupt is consumed.
  always_comb begin
    w_state_next   = r_state;
    w_take_pending = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_next = S_PRIME;
      end
      S_PRIME: begin
        if (w_last_beat) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_rows_sent == ROWS_ALL) begin
          w_state_next = S_FWAIT;
        end else if (r_pending) begin
          w_state_next   = S_ROW;
          w_take_pending = 1'b1;
        end
      end
      S_ROW: begin
        if (w_last_beat) w_state_next = S_WAIT;
      end
      S_FWAIT: begin
        if (r_flush_sent == FLUSH_ALL) begin
          w_state_next = S_DONE;
        end else if (r_pending) begin
          w_state_next   = S_FLUSH;
          w_take_pending = 1'b1;
        end
      end
      S_FLUSH: begin
        if (w_last_beat) w_state_next = S_FWAIT;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  // Read address, per-burst read/beat counters and row/flush progress.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_rd_addr    <= '0;
      r_rd_cnt     <= '0;
      r_beat_cnt   <= '0;
      r_rows_sent  <= '0;
      r_flush_sent <= '0;
    end else if (w_start) begin
      r_rd_addr    <= '0;
      r_rd_cnt     <= '0;
      r_beat_cnt   <= '0;
      r_rows_sent  <= '0;
      r_flush_sent <= '0;
    end else begin
      if (w_rd_en) begin
        r_rd_addr <= r_rd_addr + 1'b1;
        r_rd_cnt  <= r_rd_cnt + 1'b1;
      end
      if (w_beat) r_beat_cnt <= r_beat_cnt + 1'b1;
      // The burst closes on acceptance of its last beat; all reads of the
      // burst have been issued and consumed by then.
      if (w_last_beat) begin
        r_rd_cnt   <= '0;
        r_beat_cnt <= '0;
        case (r_state)
          S_PRIME: r_rows_sent  <= ROWS_PRIME;
          S_ROW:   r_rows_sent  <= r_rows_sent + 1'b1;
          S_FLUSH: r_flush_sent <= r_flush_sent + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Two-entry skid buffer plus the read-in-flight marker.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fifo_cnt <= '0;
      for (int unsigned i = 0; i < 2; i++) r_fifo_mem[i] <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_fifo_push) begin
        r_fifo_mem[r_wr_ptr] <= i_rd_data;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_fifo_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_fifo_push, w_fifo_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Interrupt edge detect, one-deep pending request and sticky overrun flag.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_intr_q  <= 1'b0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_intr_q <= i_intr;
      if (w_start) begin
        r_pending <= 1'b0;
        r_err     <= 1'b0;
      end else if (w_rise && w_intr_window) begin
        // A rise in the same cycle the pending request is consumed becomes the
        // new request rather than an overrun.
        if (r_pending && !w_take_pending) r_err <= 1'b1;
        r_pending <= 1'b1;
      end else if (w_take_pending) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done       = (r_state == S_DONE);
  assign o_err        = r_err;
  assign o_rd_en      = w_rd_en;
  assign o_rd_addr    = r_rd_addr;
  assign o_data_valid = w_valid;
  assign o_data       = w_data;
`ifdef STREAMER_TLAST_EN
  assign o_data_last  = w_valid && w_row_end;
`endif

endmodule

// File: tb/tb_image_row_streamer.sv
// tb_image_row_streamer: randomized-ready bench for image_row_streamer with a
// queue-based expected-beat model (W=8, H=6, PRIME=4, FLUSH=2, RAM[a]=a+1).
module tb_image_row_streamer;
  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;
  localparam int unsigned P  = 4;
  localparam int unsigned F  = 2;
  localparam int unsigned AW = 18;

  logic          axi_clk = 1'b0;
  logic          axi_reset = 1'b1;
  logic          i_start = 1'b0;
  logic          o_busy, o_done, o_err, o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [7:0]    i_rd_data = '0;
  logic          o_data_valid;
  logic [7:0]    o_data;
  logic          i_data_ready = 1'b0;
  logic          i_intr = 1'b0;
`ifdef STREAMER_TLAST_EN
  logic          o_data_last;
`endif

  image_row_streamer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PRIME_ROWS(P),
    .FLUSH_ROWS(F),
    .ADDR_W    (AW)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_reset   (axi_reset),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_rd_en     (o_rd_en),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .o_data_valid(o_data_valid),
    .o_data      (o_data),
    .i_data_ready(i_data_ready),
`ifdef STREAMER_TLAST_EN
    .o_data_last (o_data_last),
`endif
    .i_intr      (i_intr)
  );

  always #5 axi_clk = ~axi_clk;

  // RAM environment: one-cycle read latency, content a+1.
  always @(posedge axi_clk) begin
    if (o_rd_en) i_rd_data <= 8'(o_rd_addr + 1'b1);
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the expected beat stream of the current frame.
  logic [7:0]  exp_q[$];
  int unsigned next_row, flush_sent, exp_rd_addr, max_addr, beats, done_cnt;
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  int          ready_mode = 0;

  task automatic frame_start();
    exp_q.delete();
    for (int unsigned r = 0; r < P; r++)
      for (int unsigned c = 0; c < W; c++) exp_q.push_back(8'(r * W + c + 1));
    next_row    = P;
    flush_sent  = 0;
    exp_rd_addr = 0;
    max_addr    = 0;
    beats       = 0;
    done_cnt    = 0;
  endtask

  task automatic serve_request();
    if (next_row < H) begin
      for (int unsigned c = 0; c < W; c++) exp_q.push_back(8'(next_row * W + c + 1));
      next_row++;
    end else if (flush_sent < F) begin
      for (int unsigned c = 0; c < W; c++) exp_q.push_back(8'd0);
      flush_sent++;
    end
  endtask

  // Monitor on the falling edge: beats, stall stability, read addresses, done.
  always @(negedge axi_clk) begin
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", o_data_valid, 1);
        check_eq("hold_data", o_data, prev_data);
      end
      if (o_rd_en) begin
        check_eq("rd_addr", o_rd_addr, exp_rd_addr);
        if (o_rd_addr > max_addr) max_addr = o_rd_addr;
        exp_rd_addr++;
      end
      if (o_data_valid && i_data_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("beat_expected", 32'(exp_q.size()), 1);
        end else begin
`ifdef STREAMER_TLAST_EN
          check_eq("data_last", o_data_last, 32'((beats % W) == (W - 1)));
`endif
          check_eq("beat_data", o_data, exp_q.pop_front());
          beats++;
        end
      end
      prev_stall = o_data_valid && !i_data_ready;
      prev_data  = o_data;
      if (o_done) done_cnt++;
    end
  end

  // Ready driver.
  initial begin
    forever begin
      @(posedge axi_clk);
      #1;
      case (ready_mode)
        0:       i_data_ready = 1'b1;
        1:       i_data_ready = ~i_data_ready;
        2:       i_data_ready = ($urandom_range(0, 3) != 0);
        default: i_data_ready = 1'b0;
      endcase
    end
  end

  task automatic step(input int unsigned n = 1);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  task automatic do_start();
    frame_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic pulse_intr();
    i_intr = 1'b1;
    step();
    i_intr = 1'b0;
    step();
  endtask

  task automatic wait_drain(input string tag, input int unsigned limit);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 0);
    step(2);
  endtask

  task automatic wait_done(input string tag, input int unsigned limit);
    int unsigned n = 0;
    while (done_cnt == 0 && n < limit) begin
      step();
      n++;
    end
    step(3);
    check_eq(tag, done_cnt, 1);
    check_eq({tag, "_busy"}, o_busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rd_en"}, o_rd_en, 0);
    check_eq({tag, "_rd_addr"}, o_rd_addr, 0);
    check_eq({tag, "_valid"}, o_data_valid, 0);
    check_eq({tag, "_data"}, o_data, 0);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_done"}, o_done, 0);
    check_eq({tag, "_err"}, o_err, 0);
`ifdef STREAMER_TLAST_EN
    check_eq({tag, "_last"}, o_data_last, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;

    // Reset state
    axi_reset = 1'b1;
    step(3);
    check_all_zero("rst");
    axi_reset = 1'b0;
    step(2);
    mon_en = 1'b1;

    // Frame 1: latency, consecutive prime, two rows, two flush rows
    ready_mode = 0;
    step(2);
    do_start();
    check_eq("lat_rd_en", o_rd_en, 1);
    check_eq("lat_rd_addr", o_rd_addr, 0);
    check_eq("lat_valid_early", o_data_valid, 0);
    check_eq("lat_busy", o_busy, 1);
    step();
    check_eq("lat_valid", o_data_valid, 1);
    check_eq("lat_data", o_data, 1);
    repeat (31) @(posedge axi_clk);
    @(negedge axi_clk);
    #1;
    check_eq("prime_consecutive", 32'(exp_q.size()), 0);
    step(10);
    check_eq("prime_idle_valid", o_data_valid, 0);
    check_eq("prime_idle_busy", o_busy, 1);

    ready_mode = 2;
    serve_request();
    pulse_intr();
    step(18);
    serve_request();
    pulse_intr();
    wait_drain("rows_drain", 200);
    step(10);
    check_eq("rows_idle_valid", o_data_valid, 0);
    check_eq("rows_max_addr", max_addr, W * H - 1);
    check_eq("rows_read_count", exp_rd_addr, W * H);
    check_eq("rows_busy", o_busy, 1);

    for (int unsigned k = 0; k < F; k++) begin
      serve_request();
      pulse_intr();
      wait_drain("flush_drain", 200);
    end
    wait_done("f1_done", 20);
    check_eq("f1_beats", beats, W * (H + F));
    check_eq("f1_err", o_err, 0);
    check_eq("f1_reads", exp_rd_addr, W * H);

    // Frame 2: toggling ready during prime, interrupt overrun
    ready_mode = 1;
    do_start();
    wait_drain("f2_prime", 200);
    check_eq("f2_err_clean", o_err, 0);

    ready_mode = 3;
    serve_request();
    pulse_intr();
    n = 0;
    while (!o_data_valid && n < 20) begin
      step();
      n++;
    end
    check_eq("f2_row_active", o_data_valid, 1);
    serve_request();
    repeat (3) pulse_intr();
    ready_mode = 2;
    wait_drain("f2_rows", 200);
    step(15);
    check_eq("f2_no_extra_row", o_data_valid, 0);
    check_eq("f2_err_set", o_err, 1);
    for (int unsigned k = 0; k < F; k++) begin
      serve_request();
      pulse_intr();
      wait_drain("f2_flush", 200);
    end
    wait_done("f2_done", 20);
    check_eq("f2_err_sticky", o_err, 1);
    check_eq("f2_beats", beats, W * (H + F));

    // Frame 3: start clears error; reset in the middle of a row
    ready_mode = 2;
    do_start();
    check_eq("f3_err_cleared", o_err, 0);
    wait_drain("f3_prime", 200);
    serve_request();
    pulse_intr();
    n = 0;
    while (beats < P * W + 3 && n < 50) begin
      step();
      n++;
    end
    check_eq("f3_mid_row", 32'(beats >= P * W + 3), 1);
    mon_en    = 1'b0;
    axi_reset = 1'b1;
    step();
    check_all_zero("midrst");
    axi_reset = 1'b0;
    step(3);
    check_all_zero("postrst");
    mon_en = 1'b1;

    // Frame 4: full frame with random ready; start ignored while busy
    do_start();
    step();
    check_eq("f4_first_data", o_data, 1);
    check_eq("f4_first_valid", o_data_valid, 1);
    wait_drain("f4_prime", 200);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step(5);
    check_eq("f4_start_ignored", o_data_valid, 0);
    check_eq("f4_start_ignored_rd", o_rd_en, 0);
    for (int unsigned k = 0; k < (H - P) + F; k++) begin
      serve_request();
      pulse_intr();
      wait_drain("f4_burst", 200);
    end
    wait_done("f4_done", 20);
    check_eq("f4_beats", beats, W * (H + F));
    check_eq("f4_reads", exp_rd_addr, W * H);
    check_eq("f4_err", o_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
